// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
// Byte FIFO between the memory-mapped UART write port and the transmitter.
// Producer side: WrData/WrValid/WrReady. Consumer side: DataOut/DataOutValid/DataOutReady.
// Pointers carry one extra wrap bit so full and empty are told apart without a separate flag.
// Every output is a function of registered state only; there is no empty-FIFO bypass.

module uart_tx_fifo #(
   parameter int Depth = 16,
   parameter int Width = 8,
   localparam int AW = $clog2(Depth)
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic [Width-1:0] WrData,
   input  logic             WrValid,
   output logic             WrReady,
   output logic [Width-1:0] DataOut,
   output logic             DataOutValid,
   input  logic             DataOutReady,
   output logic [AW:0]      Count,
   output logic             Overflow,
   input  logic             OverflowClear
);

   // Storage and state
   logic [Width-1:0] mem [Depth];
   logic [AW:0]      wr_ptr_reg;
   logic [AW:0]      wr_ptr_next;
   logic [AW:0]      rd_ptr_reg;
   logic [AW:0]      rd_ptr_next;
   logic             overflow_reg;
   logic             overflow_next;

   logic [AW-1:0]    wr_idx;
   logic [AW-1:0]    rd_idx;
   logic             empty;
   logic             full;
   logic             enq;
   logic             deq;

   assign wr_idx = wr_ptr_reg[AW-1:0];
   assign rd_idx = rd_ptr_reg[AW-1:0];
   assign empty  = (wr_ptr_reg == rd_ptr_reg);
   assign full   = (wr_idx == rd_idx) && (wr_ptr_reg[AW] != rd_ptr_reg[AW]);

   // WrReady ignores DataOutReady: a write offered while full is refused
   // even if the head byte leaves in the same cycle.
   assign enq = WrValid && !full;
   assign deq = DataOutReady && !empty;

   // Pointer and overflow next-state; a set request beats a clear in the same cycle
   always_comb begin
      wr_ptr_next   = wr_ptr_reg;
      rd_ptr_next   = rd_ptr_reg;
      overflow_next = overflow_reg;
      if (enq) begin
         wr_ptr_next = wr_ptr_reg + 1'b1;
      end
      if (deq) begin
         rd_ptr_next = rd_ptr_reg + 1'b1;
      end
      if (WrValid && full) begin
         overflow_next = 1'b1;
      end else if (OverflowClear) begin
         overflow_next = 1'b0;
      end
   end

   // State register; reset overrides every handshake, array contents are left alone
   always_ff @(posedge Clock) begin
      if (Reset) begin
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         overflow_reg <= 1'b0;
      end else begin
         wr_ptr_reg   <= wr_ptr_next;
         rd_ptr_reg   <= rd_ptr_next;
         overflow_reg <= overflow_next;
      end
   end

   // One write-enabled register per entry
   for (genvar gi = 0; gi < Depth; gi++) begin : g_entry
      // Capture the offered byte into this entry when it is the write slot
      always_ff @(posedge Clock) begin
         if (!Reset && enq && (wr_idx == AW'(gi))) begin
            mem[gi] <= WrData;
         end
      end
   end

   // Outputs
   assign WrReady      = !full;
   assign DataOutValid = !empty;
   assign DataOut      = empty ? '0 : mem[rd_idx];
   assign Count        = wr_ptr_reg - rd_ptr_reg;
   assign Overflow     = overflow_reg;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo
// Directed bench for uart_tx_fifo: reset, single byte, fill/overflow,
// full with simultaneous dequeue, wrap-around streaming, reset mid-operation.

module tb_uart_tx_fifo;

   logic       Clock = 1'b0;
   logic       Reset = 1'b0;
   logic [7:0] WrData = 8'h00;
   logic       WrValid = 1'b0;
   logic       WrReady;
   logic [7:0] DataOut;
   logic       DataOutValid;
   logic       DataOutReady = 1'b0;
   logic [4:0] Count;
   logic       Overflow;
   logic       OverflowClear = 1'b0;

   int pass_count = 0;
   int check_count = 0;

   uart_tx_fifo #(.Depth(16), .Width(8)) dut (
      .Clock(Clock),
      .Reset(Reset),
      .WrData(WrData),
      .WrValid(WrValid),
      .WrReady(WrReady),
      .DataOut(DataOut),
      .DataOutValid(DataOutValid),
      .DataOutReady(DataOutReady),
      .Count(Count),
      .Overflow(Overflow),
      .OverflowClear(OverflowClear)
   );

   always #5 Clock = ~Clock;

   // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge
   task automatic step();
      @(posedge Clock);
      #1;
   endtask

   task automatic test_reset();
      Reset = 1'b1;
      step();
      Reset = 1'b0;
      check_count++;
      if (WrReady !== 1'b1) $display("FAIL reset_wrready got %0b want 1", WrReady);
      else pass_count++;
      check_count++;
      if (DataOutValid !== 1'b0) $display("FAIL reset_valid got %0b want 0", DataOutValid);
      else pass_count++;
      check_count++;
      if (Count !== 5'd0) $display("FAIL reset_count got %0d want 0", Count);
      else pass_count++;
      check_count++;
      if (Overflow !== 1'b0) $display("FAIL reset_overflow got %0b want 0", Overflow);
      else pass_count++;
      check_count++;
      if (DataOut !== 8'h00) $display("FAIL reset_dataout got %h want 00", DataOut);
      else pass_count++;
      $display("reset: WrReady=%0b DataOutValid=%0b Count=%0d Overflow=%0b DataOut=%h",
               WrReady, DataOutValid, Count, Overflow, DataOut);
   endtask

   task automatic test_single_byte();
      WrData = 8'hA5;
      WrValid = 1'b1;
      step();
      WrValid = 1'b0;
      check_count++;
      if (DataOutValid !== 1'b1) $display("FAIL single_valid got %0b want 1", DataOutValid);
      else pass_count++;
      check_count++;
      if (DataOut !== 8'hA5) $display("FAIL single_data got %h want a5", DataOut);
      else pass_count++;
      check_count++;
      if (Count !== 5'd1) $display("FAIL single_count got %0d want 1", Count);
      else pass_count++;
      DataOutReady = 1'b1;
      step();
      DataOutReady = 1'b0;
      check_count++;
      if (DataOutValid !== 1'b0) $display("FAIL single_drain_valid got %0b want 0", DataOutValid);
      else pass_count++;
      check_count++;
      if (Count !== 5'd0) $display("FAIL single_drain_count got %0d want 0", Count);
      else pass_count++;
      $display("single: wrote a5, read back, Count=%0d", Count);
   endtask

   task automatic test_fill_overflow();
      for (int i = 0; i < 16; i++) begin
         WrData = 8'(i);
         WrValid = 1'b1;
         step();
      end
      WrValid = 1'b0;
      check_count++;
      if (WrReady !== 1'b0) $display("FAIL fill_wrready got %0b want 0", WrReady);
      else pass_count++;
      check_count++;
      if (Count !== 5'd16) $display("FAIL fill_count got %0d want 16", Count);
      else pass_count++;
      WrData = 8'hFF;
      WrValid = 1'b1;
      step();
      WrValid = 1'b0;
      check_count++;
      if (Overflow !== 1'b1) $display("FAIL fill_overflow got %0b want 1", Overflow);
      else pass_count++;
      check_count++;
      if (Count !== 5'd16) $display("FAIL fill_count_after_refuse got %0d want 16", Count);
      else pass_count++;
      for (int i = 0; i < 16; i++) begin
         check_count++;
         if (DataOutValid !== 1'b1 || DataOut !== 8'(i))
            $display("FAIL drain_order[%0d] got valid=%0b data=%h want valid=1 data=%h",
                     i, DataOutValid, DataOut, 8'(i));
         else pass_count++;
         DataOutReady = 1'b1;
         step();
         DataOutReady = 1'b0;
      end
      check_count++;
      if (DataOutValid !== 1'b0 || Count !== 5'd0)
         $display("FAIL drain_empty got valid=%0b count=%0d want valid=0 count=0",
                  DataOutValid, Count);
      else pass_count++;
      check_count++;
      if (Overflow !== 1'b1) $display("FAIL overflow_sticky got %0b want 1", Overflow);
      else pass_count++;
      OverflowClear = 1'b1;
      step();
      OverflowClear = 1'b0;
      check_count++;
      if (Overflow !== 1'b0) $display("FAIL overflow_clear got %0b want 0", Overflow);
      else pass_count++;
      $display("fill_overflow: 16 bytes drained in order, Overflow cleared=%0b", !Overflow);
   endtask

   task automatic test_full_dequeue();
      for (int i = 0; i < 16; i++) begin
         WrData = 8'h40 + 8'(i);
         WrValid = 1'b1;
         step();
      end
      WrData = 8'hEE;
      WrValid = 1'b1;
      DataOutReady = 1'b1;
      step();
      WrValid = 1'b0;
      DataOutReady = 1'b0;
      check_count++;
      if (Overflow !== 1'b1) $display("FAIL fulldeq_overflow got %0b want 1", Overflow);
      else pass_count++;
      check_count++;
      if (Count !== 5'd15) $display("FAIL fulldeq_count got %0d want 15", Count);
      else pass_count++;
      check_count++;
      if (WrReady !== 1'b1) $display("FAIL fulldeq_wrready got %0b want 1", WrReady);
      else pass_count++;
      for (int i = 1; i < 16; i++) begin
         check_count++;
         if (DataOut !== 8'h40 + 8'(i))
            $display("FAIL fulldeq_drain[%0d] got %h want %h", i, DataOut, 8'h40 + 8'(i));
         else pass_count++;
         DataOutReady = 1'b1;
         step();
         DataOutReady = 1'b0;
      end
      check_count++;
      if (DataOutValid !== 1'b0) $display("FAIL fulldeq_ee_not_stored got valid=%0b want 0", DataOutValid);
      else pass_count++;
      $display("full_dequeue: refused write with concurrent read, Count went 16->15");
   endtask

   // 40 bytes 10..37: preload 5, then write and read every cycle, then drain
   task automatic test_back_to_back();
      int wr_n = 0;
      int rd_n = 0;
      for (int i = 0; i < 5; i++) begin
         WrData = 8'h10 + 8'(wr_n);
         WrValid = 1'b1;
         step();
         wr_n++;
      end
      WrValid = 1'b0;
      while (rd_n < 40) begin
         check_count++;
         if (DataOutValid !== 1'b1 || DataOut !== 8'h10 + 8'(rd_n))
            $display("FAIL wrap_data[%0d] got valid=%0b data=%h want %h",
                     rd_n, DataOutValid, DataOut, 8'h10 + 8'(rd_n));
         else pass_count++;
         check_count++;
         if (Count !== 5'(wr_n - rd_n))
            $display("FAIL wrap_count[%0d] got %0d want %0d", rd_n, Count, wr_n - rd_n);
         else pass_count++;
         WrValid = (wr_n < 40);
         WrData = 8'h10 + 8'(wr_n);
         DataOutReady = 1'b1;
         step();
         if (wr_n < 40) wr_n++;
         rd_n++;
      end
      WrValid = 1'b0;
      DataOutReady = 1'b0;
      check_count++;
      if (DataOutValid !== 1'b0 || Count !== 5'd0)
         $display("FAIL wrap_end got valid=%0b count=%0d want 0 0", DataOutValid, Count);
      else pass_count++;
      $display("back_to_back: streamed %0d bytes through wrapped pointers", rd_n);
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 5; i++) begin
         WrData = 8'h80 + 8'(i);
         WrValid = 1'b1;
         step();
      end
      WrValid = 1'b0;
      check_count++;
      if (Count !== 5'd5) $display("FAIL midreset_pre_count got %0d want 5", Count);
      else pass_count++;
      check_count++;
      if (Overflow !== 1'b1) $display("FAIL midreset_pre_overflow got %0b want 1", Overflow);
      else pass_count++;
      Reset = 1'b1;
      WrValid = 1'b1;
      WrData = 8'h99;
      step();
      Reset = 1'b0;
      WrValid = 1'b0;
      check_count++;
      if (Count !== 5'd0) $display("FAIL midreset_count got %0d want 0", Count);
      else pass_count++;
      check_count++;
      if (DataOutValid !== 1'b0) $display("FAIL midreset_valid got %0b want 0", DataOutValid);
      else pass_count++;
      check_count++;
      if (Overflow !== 1'b0) $display("FAIL midreset_overflow got %0b want 0", Overflow);
      else pass_count++;
      WrData = 8'h3C;
      WrValid = 1'b1;
      step();
      WrValid = 1'b0;
      check_count++;
      if (DataOutValid !== 1'b1 || DataOut !== 8'h3C)
         $display("FAIL midreset_first got valid=%0b data=%h want 1 3c", DataOutValid, DataOut);
      else pass_count++;
      check_count++;
      if (Count !== 5'd1) $display("FAIL midreset_after_count got %0d want 1", Count);
      else pass_count++;
      $display("reset_mid: stored bytes discarded, first byte after reset=%h", DataOut);
   endtask

   initial begin
      #1;
      test_reset();
      test_single_byte();
      test_fill_overflow();
      test_full_dequeue();
      test_back_to_back();
      test_reset_mid();
      $display("%0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

endmodule
